// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of the UART TX FIFO between four byte-stream requesters
module uart_tx_arbiter #(
  parameter bit HEADER_EN = 1'b1,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  valid_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  last_i,
  output logic [3:0]  ready_o,
  output logic [7:0]  fifo_data_o,
  output logic        n_fifo_we_o,
  input  logic        p_fifo_full_i,
  output logic [3:0]  grant_o,
  output logic        busy_o,
  output logic [7:0]  abort_cnt_o
);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_n;
  logic [1:0] rr, g, sel;
  logic [15:0] wd;
  logic slot_ok, vg, xfer, timeout, wr;
  logic [7:0] wr_data;
  // a pending write holds n_fifo_we_o low, so the slot also waits for full to catch up
  assign slot_ok = !p_fifo_full_i && n_fifo_we_o;
  assign vg = valid_i[g];
  assign xfer = state == DATA && vg && slot_ok;
  assign timeout = state == DATA && !vg && wd == TIMEOUT - 16'd1;
  assign busy_o = state != IDLE;
  assign grant_o = busy_o ? 4'b0001 << g : 4'b0000;
  assign ready_o = (state == DATA && slot_ok) ? 4'b0001 << g : 4'b0000;
  always_comb begin
    sel = rr;
    for (int i = 4; i >= 1; i--) if (valid_i[rr + 2'(i)]) sel = rr + 2'(i);
  end
  always_comb begin
    state_n = state;
    wr = 1'b0;
    wr_data = data_i[{g, 3'b000} +: 8];
    unique case (state)
      IDLE: if (|valid_i) begin
        if (HEADER_EN) state_n = HDR;
        else state_n = DATA;
      end
      HDR: if (slot_ok) begin
        state_n = DATA;
        wr = 1'b1;
        wr_data = {4'hA, 2'b00, g};
      end
      DATA: begin
        wr = xfer;
        if ((xfer && last_i[g]) || timeout) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= 2'd3;
      g <= 2'd0;
      wd <= 16'd0;
      abort_cnt_o <= 8'd0;
      n_fifo_we_o <= 1'b1;
      fifo_data_o <= 8'd0;
    end else begin
      n_fifo_we_o <= !wr;
      if (wr) fifo_data_o <= wr_data;
      if (state == IDLE && |valid_i) begin
        g <= sel;
        rr <= sel;
      end
      // backpressure stalls (valid high, no slot) hold the count
      wd <= (state != DATA || xfer || timeout) ? 16'd0 : vg ? wd : wd + 16'd1;
      if (timeout && abort_cnt_o != 8'hFF) abort_cnt_o <= abort_cnt_o + 8'd1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random and directed stimulus checked every cycle against a frame-level model
module tb_uart_tx_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1, p_fifo_full_i = 1'b0;
  logic [3:0] valid_i = 4'h0, last_i = 4'h0;
  logic [31:0] data_i = 32'h0;
  logic [3:0] ready_o, grant_o;
  logic [7:0] fifo_data_o, abort_cnt_o;
  logic n_fifo_we_o, busy_o;

  uart_tx_arbiter #(.HEADER_EN(1'b1), .TIMEOUT(16'(TO))) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .last_i(last_i),
    .ready_o(ready_o), .fifo_data_o(fifo_data_o), .n_fifo_we_o(n_fifo_we_o),
    .p_fifo_full_i(p_fifo_full_i), .grant_o(grant_o), .busy_o(busy_o),
    .abort_cnt_o(abort_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: owner of the frame (-1 idle), last owner served, header still owed,
  // run of consecutive idle cycles, and the byte written in the previous cycle
  int m_own = -1, m_last = 3, m_run = 0;
  bit m_hdr = 0, m_wrote = 0;
  logic [7:0] m_byte = 8'h00, m_ab = 8'h00;
  logic [3:0] took = 4'h0, prev_grant = 4'h0;
  logic prev_we = 1'b1;
  logic [7:0] wlog[$];
  logic [3:0] glog[$];
  logic [8:0] q[4][$];
  bit rnd = 0;

  always @(negedge clk) begin
    logic can;
    logic [3:0] eg, er;
    int p;
    can = !p_fifo_full_i && !m_wrote;
    eg = m_own < 0 ? 4'h0 : 4'h1 << m_own;
    er = (m_own >= 0 && !m_hdr && can) ? eg : 4'h0;
    chk("grant", grant_o, eg);
    chk("busy", busy_o, m_own >= 0);
    chk("ready", ready_o, er);
    chk("n_we", n_fifo_we_o, !m_wrote);
    chk("fifo_data", fifo_data_o, m_byte);
    chk("abort_cnt", abort_cnt_o, m_ab);
    if (!n_fifo_we_o) begin
      wlog.push_back(fifo_data_o);
      chk("we_spacing", prev_we, 1'b1);
    end
    prev_we = n_fifo_we_o;
    if (grant_o != 4'h0 && grant_o != prev_grant) glog.push_back(grant_o);
    prev_grant = grant_o;
    took = valid_i & ready_o;
    m_wrote = 0;
    p = -1;
    if (rst) begin
      m_own = -1; m_last = 3; m_run = 0; m_hdr = 0; m_byte = 8'h00; m_ab = 8'h00;
    end else if (m_own < 0) begin
      for (int i = 1; i <= 4; i++) if (p < 0 && valid_i[(m_last + i) % 4]) p = (m_last + i) % 4;
      if (p >= 0) begin m_own = p; m_last = p; m_hdr = 1; m_run = 0; end
    end else if (m_hdr) begin
      if (can) begin m_wrote = 1; m_byte = 8'hA0 | 8'(m_own); m_hdr = 0; end
    end else if (valid_i[m_own]) begin
      if (can) begin
        m_wrote = 1; m_byte = data_i[8*m_own +: 8]; m_run = 0;
        if (last_i[m_own]) m_own = -1;
      end
    end else if (++m_run == TO) begin
      m_own = -1; m_run = 0;
      if (m_ab != 8'hFF) m_ab++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (took[k] && q[k].size() > 0) void'(q[k].pop_front());
      valid_i[k] = q[k].size() > 0 && (!rnd || $urandom_range(3) != 0);
      data_i[8*k +: 8] = q[k].size() > 0 ? q[k][0][7:0] : 8'h00;
      last_i[k] = q[k].size() > 0 && q[k][0][8];
    end
    if (rnd) p_fifo_full_i = $urandom_range(3) == 0;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  function automatic bit pending();
    return busy_o || q[0].size() > 0 || q[1].size() > 0 || q[2].size() > 0 || q[3].size() > 0;
  endfunction

  task automatic drain(int lim, string nm);
    int c = 0;
    while (pending() && c < lim) begin step(); c++; end
    chk({nm, "_done"}, c < lim, 1'b1);
    run(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) q[k].delete();
    valid_i = 4'h0; last_i = 4'h0; p_fifo_full_i = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] e1[4] = '{8'hA2, 8'h11, 8'h22, 8'h33};
    logic [7:0] e3[5] = '{8'hA1, 8'h51, 8'h52, 8'h53, 8'h54};
    logic [3:0] e2[5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    int c, idle, bad;
    run(2);
    rst = 1'b0;
    chk("reset_grant", grant_o, 4'h0);
    chk("reset_n_we", n_fifo_we_o, 1'b1);

    wlog.delete(); glog.delete();
    q[2] = '{9'h011, 9'h022, 9'h133};
    drain(100, "single");
    chk("single_len", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk("single_byte", wlog[i], e1[i]);
    chk("single_grants", glog.size(), 1);
    chk("single_grant", glog[0], 4'b0100);
    chk("single_grant_end", grant_o, 4'h0);

    do_reset();
    glog.delete();
    for (int k = 0; k < 4; k++) begin
      q[k].push_back({1'b1, 8'(k)});
      q[k].push_back({1'b1, 8'(k + 4)});
    end
    drain(300, "rr");
    chk("rr_count", glog.size(), 8);
    for (int i = 0; i < 5; i++) chk("rr_order", glog[i], e2[i]);

    wlog.delete();
    q[1] = '{9'h051, 9'h052, 9'h053, 9'h154};
    c = 0;
    while (wlog.size() < 2 && c < 50) begin step(); c++; end
    chk("bp_start", c < 50, 1'b1);
    p_fifo_full_i = 1'b1;
    bad = 0;
    repeat (50) begin
      step();
      if (ready_o != 4'h0 || !n_fifo_we_o) bad++;
    end
    chk("bp_quiet", bad, 0);
    p_fifo_full_i = 1'b0;
    drain(100, "bp");
    chk("bp_len", wlog.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_byte", wlog[i], e3[i]);
    chk("bp_no_abort", abort_cnt_o, 8'h00);

    q[3].push_back(9'h077);
    c = 0; idle = 0;
    while (pending() && c < 100) begin
      step(); c++;
      if (grant_o == 4'b1000 && !valid_i[3]) idle++;
    end
    chk("wd_done", c < 100, 1'b1);
    chk("wd_idle_cycles", idle, TO);
    chk("wd_abort_cnt", abort_cnt_o, 8'h01);
    chk("wd_grant_clear", grant_o, 4'h0);
    glog.delete();
    q[0].push_back(9'h1C0);
    q[1].push_back(9'h1C1);
    drain(100, "wd_next");
    chk("wd_next_grant", glog[0], 4'b0001);

    for (int n = 0; n < 260; n++) begin
      q[n % 4].push_back(9'h055);
      drain(100, "sat");
    end
    chk("sat_abort_cnt", abort_cnt_o, 8'hFF);

    q[2] = '{9'h0E1, 9'h0E2, 9'h1E3};
    c = 0;
    while (!busy_o && c < 20) begin step(); c++; end
    run(3);
    chk("mid_busy", busy_o, 1'b1);
    do_reset();
    chk("rst_grant", grant_o, 4'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", ready_o, 4'h0);
    chk("rst_n_we", n_fifo_we_o, 1'b1);
    chk("rst_data", fifo_data_o, 8'h00);
    chk("rst_abort", abort_cnt_o, 8'h00);
    glog.delete();
    for (int k = 0; k < 4; k++) q[k].push_back({1'b1, 8'h90 + 8'(k)});
    drain(200, "post_rst");
    chk("post_rst_grant", glog[0], 4'b0001);

    rnd = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) begin
        int k, len;
        k = $urandom_range(3);
        len = $urandom_range(4, 1);
        if (q[k].size() < 8)
          for (int i = 0; i < len; i++)
            q[k].push_back({i == len - 1 && $urandom_range(7) != 0, 8'($urandom)});
      end
      if ($urandom_range(499) == 0) do_reset();
      else step();
    end
    rnd = 0;
    p_fifo_full_i = 1'b0;
    drain(1000, "random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
